// File: rtl/pooling_pkg.sv
// Shared types and constants for the 2x2 pooling job controller.
package pooling_pkg;

    localparam int unsigned DIM_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned POOL_LAT   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pool_window_counter.sv
// Nested row/column window counter: column wraps into row, last flags the final window.
module pool_window_counter #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] col_max_i,
    input  logic [CNT_W-1:0] row_max_i,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o,
    output logic             last_c_o
);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_q == col_max_i) begin
                col_d = '0;
                row_d = (row_q == row_max_i) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o    = row_q;
    assign col_o    = col_q;
    assign last_c_o = (col_q == col_max_i) && (row_q == row_max_i);

endmodule

// File: rtl/pooling_controller.sv
// Sequences 2x2 window fetches for a pooling datapath and issues the
// matching output writes a fixed pipeline latency later.
module pooling_controller
    import pooling_pkg::*;
#(
    parameter int unsigned DIM_W  = DIM_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              mode,
    input  logic [DIM_W-1:0]  in_rows,
    input  logic [DIM_W-1:0]  in_cols,
    output logic              rd_req,
    output logic [DIM_W-1:0]  rd_row,
    output logic [DIM_W-1:0]  rd_col,
    input  logic              rd_valid,
    output logic              start_pool,
    output logic              ctrl_pool,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int unsigned CNT_W = DIM_W - 1;
    localparam int unsigned DRN_W = (POOL_LAT > 1) ? $clog2(POOL_LAT) : 1;

    state_e            state_q, state_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic [CNT_W-1:0]  row_max_q, col_max_q;
    logic [CNT_W-1:0]  win_row, win_col;
    logic              win_last;
    logic              mode_q;
    logic              cfg_err_q;
    logic [ADDR_W-1:0] idx_q;
    logic              vld_q  [POOL_LAT];
    logic [ADDR_W-1:0] addr_q [POOL_LAT];

    logic dims_ok;
    logic job_accept;
    logic cfg_reject;
    logic win_accept;

    assign dims_ok    = (in_rows >= DIM_W'(2)) && (in_cols >= DIM_W'(2));
    assign job_accept = start && (state_q == IDLE) && dims_ok;
    assign cfg_reject = start && (state_q == IDLE) && !dims_ok;
    assign win_accept = rd_valid && (state_q == ISSUE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drn_d   = '0;
        case (state_q)
            IDLE: begin
                if (job_accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (win_accept && win_last) state_d = DRAIN;
            end
            DRAIN: begin
                drn_d = drn_q + DRN_W'(1);
                if (drn_q == DRN_W'(POOL_LAT - 1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_req = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (state_q)
            IDLE:    busy   = 1'b0;
            ISSUE:   rd_req = 1'b1;
            DONE:    done   = 1'b1;
            default: ;
        endcase
    end

    // Job configuration is frozen at accept; window limits are stored as max indices.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_max_q <= '0;
            col_max_q <= '0;
            mode_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_reject;
            if (job_accept) begin
                row_max_q <= CNT_W'(in_rows >> 1) - CNT_W'(1);
                col_max_q <= CNT_W'(in_cols >> 1) - CNT_W'(1);
                mode_q    <= mode;
            end
        end
    end

    pool_window_counter #(
        .CNT_W (CNT_W)
    ) u_win_cnt (
        .clk       (clk),
        .nrst      (nrst),
        .clr_i     (job_accept),
        .inc_i     (win_accept),
        .col_max_i (col_max_q),
        .row_max_i (row_max_q),
        .row_o     (win_row),
        .col_o     (win_col),
        .last_c_o  (win_last)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q <= '0;
        end else if (job_accept) begin
            idx_q <= '0;
        end else if (win_accept) begin
            idx_q <= idx_q + ADDR_W'(1);
        end
    end

    // Write latency pipeline runs regardless of FSM state so the tail drains during DRAIN.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < POOL_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= win_accept;
            if (win_accept) addr_q[0] <= idx_q;
            for (int unsigned i = 1; i < POOL_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign rd_row     = {win_row, 1'b0};
    assign rd_col     = {win_col, 1'b0};
    assign start_pool = win_accept;
    assign ctrl_pool  = mode_q;
    assign wr_en      = vld_q[POOL_LAT-1];
    assign wr_addr    = addr_q[POOL_LAT-1];
    assign cfg_err    = cfg_err_q;

endmodule
